mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 32x8 synchronous memory between NUM_REQ independent requesters.
- Each requester posts a read or write. The arbiter grants one requester at a time and drives the memory read/write/addr/data_in pins.
- For reads, it captures data_out and returns it with a one-cycle ack pulse.
- Sits between test/bus masters and the memory design modport, replacing direct task-driven access.

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 72 +++++++
 tb/tb_mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake and memory-pin bundle shared by mem_arbiter and its masters
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0] ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic busy;
  logic mem_read;
  logic mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  modport slave (
    input req, req_we, req_addr, req_wdata, mem_data_out,
    output ack, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
  );
  modport master (
    output req, req_we, req_addr, req_wdata, mem_data_out,
    input ack, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous memory between NUM_REQ requesters
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  state_t state_q;
  logic [IW-1:0] rr_q, gnt_q, sel_d;
  logic we_q, busy_q, mem_read_q, mem_write_q;
  logic [NUM_REQ-1:0] ack_q, elig_d;
  logic [DATA_WIDTH-1:0] rdata_q, mem_data_in_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  always_comb begin
    elig_d = bus.req & ~ack_q;
    sel_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig_d[(int'(rr_q) + k) % NUM_REQ]) sel_d = IW'((int'(rr_q) + k) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      ack_q <= '0;
      rdata_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      ack_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: if (|elig_d) begin
          state_q <= ACCESS;
          busy_q <= 1'b1;
          gnt_q <= sel_d;
          we_q <= bus.req_we[sel_d];
          mem_write_q <= bus.req_we[sel_d];
          mem_read_q <= !bus.req_we[sel_d];
          mem_addr_q <= bus.req_addr[sel_d*ADDR_WIDTH +: ADDR_WIDTH];
          mem_data_in_q <= bus.req_we[sel_d] ? bus.req_wdata[sel_d*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        ACCESS: state_q <= CAPTURE;
        CAPTURE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          ack_q <= NUM_REQ'(1) << gnt_q;
          rr_q <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          if (!we_q) rdata_q <= bus.mem_data_out;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ack = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy = busy_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a round-robin reference model
module tb_mem_arbiter;
  localparam int N = 4;
  localparam int AW = 5;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int rr = 0;
  int n_wr = 0;
  logic prev_strobe = 1'b0;
  logic [AW-1:0] last_waddr;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] tb_mem [32];
  logic [DW-1:0] ref_mem [32];
  mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_read) bus.mem_data_out <= tb_mem[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      chk("strobe_overlap", 32'(bus.mem_read & bus.mem_write), 0);
      chk("strobe_width", 32'(prev_strobe), 0);
      chk("busy_access", 32'(bus.busy), 1);
      if (bus.mem_read) chk("read_data_in", 32'(bus.mem_data_in), 0);
      if (bus.mem_write) begin
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_data_in;
        n_wr++;
      end
    end
    if (bus.ack != '0) begin
      chk("ack_onehot", $countones(bus.ack), 1);
      chk("busy_ack", 32'(bus.busy), 0);
    end
    prev_strobe = bus.mem_read | bus.mem_write;
  end
  function automatic int pick(input logic [N-1:0] p, input int r);
    for (int k = 0; k < N; k++) if (p[(r + k) % N]) return (r + k) % N;
    return 0;
  endfunction
  task automatic run_set(input logic [N-1:0] mask, input logic [N-1:0] we, input logic [N*AW-1:0] addr,
                         input logic [N*DW-1:0] wd, input int ntx, input bit hold);
    logic [N-1:0] pend;
    logic [AW-1:0] a;
    int win, n, lat;
    @(negedge clk);
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req = mask;
    pend = mask;
    lat = 3;
    for (int t = 0; t < ntx; t++) begin
      win = pick(pend, rr);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.ack == '0 && n < 12);
      chk("ack_grant", 32'(bus.ack), 32'(1) << win);
      chk("ack_latency", n, lat);
      a = addr[win*AW +: AW];
      if (we[win]) ref_mem[a] = wd[win*DW +: DW];
      else chk("rdata", 32'(bus.rdata), 32'(ref_mem[a]));
      rr = (win + 1) % N;
      if (!hold) pend[win] = 1'b0;
      lat = (hold && (pend & ~(N'(1) << win)) == '0) ? 4 : 3;
      bus.req = (t == ntx - 1) ? '0 : pend;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end
  initial begin
    logic [N-1:0] m, w;
    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv;
    bit h;
    int n;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    bus.req = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd", 32'(bus.mem_read), 0);
    chk("rst_wr", 32'(bus.mem_write), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_din", 32'(bus.mem_data_in), 0);
    rst = 1'b0;
    n = n_wr;
    run_set(4'b0001, 4'b0001, 20'h0000A, 32'h5C, 1, 1'b0);
    chk("w1_count", n_wr - n, 1);
    chk("w1_addr", 32'(last_waddr), 32'h0A);
    chk("w1_data", 32'(last_wdata), 32'h5C);
    run_set(4'b0001, 4'b0000, 20'h0000A, 32'h0, 1, 1'b0);
    chk("r1_rdata", 32'(bus.rdata), 32'h5C);
    run_set(4'b1111, 4'b0000, (N*AW)'($urandom), 32'h0, 8, 1'b1);
    run_set(4'b0100, 4'b0000, 20'h0, 32'h0, 1, 1'b0);
    chk("wrap_rr", rr, 3);
    run_set(4'b1001, 4'b0000, 20'h0, 32'h0, 2, 1'b0);
    run_set(4'b0010, 4'b0010, 20'h00060, 32'h00007700, 2, 1'b1);
    run_set(4'b0100, 4'b0100, 20'h07C00, 32'h00A30000, 1, 1'b0);
    @(negedge clk);
    bus.req_we = '0;
    bus.req_addr = 20'h0001F;
    bus.req = 4'b0001;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_read && n < 10);
    chk("rst_mid_access", 32'(bus.mem_read), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    chk("rstm_rd", 32'(bus.mem_read), 0);
    chk("rstm_wr", 32'(bus.mem_write), 0);
    chk("rstm_busy", 32'(bus.busy), 0);
    chk("rstm_rdata", 32'(bus.rdata), 0);
    chk("rstm_addr", 32'(bus.mem_addr), 0);
    rr = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rstm_no_ack", 32'(bus.ack), 0);
    end
    run_set(4'b1000, 4'b0000, 20'h F8000, 32'h0, 1, 1'b0);
    chk("rstm_readback", 32'(bus.rdata), 32'hA3);
    for (int a = 0; a < 32; a++) begin
      av = '0;
      dv = '0;
      av[(a % N)*AW +: AW] = AW'(a);
      dv[(a % N)*DW +: DW] = DW'(8'hFF - a);
      run_set(N'(1) << (a % N), N'(1) << (a % N), av, dv, 1, 1'b0);
    end
    for (int a = 0; a < 32; a++) begin
      av = '0;
      av[((a + 1) % N)*AW +: AW] = AW'(a);
      run_set(N'(1) << ((a + 1) % N), '0, av, '0, 1, 1'b0);
      chk("sweep_rdata", 32'(bus.rdata), 32'(8'hFF - a));
    end
    for (int i = 0; i < 25; i++) begin
      m = N'($urandom_range(1, 15));
      w = N'($urandom);
      av = (N*AW)'($urandom);
      dv = (N*DW)'($urandom);
      h = 1'($urandom_range(0, 1));
      run_set(m, w, av, dv, h ? $urandom_range(1, 6) : $countones(m), h);
    end
    repeat (4) @(negedge clk);
    chk("end_idle", 32'(bus.busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
